vertex_transform: RTL and testbench
===================================

# vertex_transform

Sequential consumer of the 4x4 Q8.8 matrices produced by the MVP matrix generators (view, model, projection). It accepts one vertex (x, y, z, implicit w = 1.0) over a valid/ready handshake and multiplies it by a latched 4x4 matrix using a single shared multiply-accumulate unit. It returns the homogeneous result (x', y', z', w') over a second valid/ready handshake. It sits between the matrix generators and the rasterizer's perspective-divide stage.

## Interface
- No parameters. Fixed format: signed Q8.8, 16 bits, 8 fractional bits.
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- matrix  in  [15:0][15:0]  row-major; element (r,c) at index r*4+c (translation column at indices 3, 7, 11, 15)
- in_x, in_y, in_z  in  16 each  vertex coordinates, Q8.8
- in_valid  in  1  vertex and matrix presented
- in_ready  out  1  block can accept; high only in IDLE
- out_x, out_y, out_z, out_w  out  16 each  transformed coordinates, Q8.8
- out_valid  out  1  result presented
- out_ready  in  1  downstream accepts result

## Operation
- States:
  - IDLE: in_ready = 1.
  - MAC: 16 steps, index k = 0..15, with r = k/4 and c = k%4.
  - DONE: out_valid = 1.
- IDLE -> MAC on in_valid & in_ready.
  - On that edge, latch all 16 matrix elements, plus in_x, in_y, in_z, with w = 16'h0100.
  - Clear the accumulator and set k = 0.
  - Input changes after acceptance have no effect.
- MAC step k:
  - product = signed matrix(r,c) * signed v[c], where v = {x, y, z, w}; 32-bit, Q16.16.
  - acc = acc + product; acc is 36-bit signed.
- At c = 3:
  - result = (acc + product) >>> 8, arithmetic shift, truncating toward negative infinity.
  - Saturate the result to [16'h8000, 16'h7FFF] and write it to output register r (0 = x, 1 = y, 2 = z, 3 = w).
  - Clear the accumulator for the next row.
- After k = 15: MAC -> DONE.
- DONE -> IDLE on out_ready. Outputs hold their values until the next result overwrites them.
- out_* registers hold stable for the whole time out_valid is high.
- No bypass: in_ready is 0 in the cycle the output handshake completes.

## Timing
- Reset values: in_ready = 0 while Reset is high, then 1 in the first cycle after Reset deasserts. out_valid = 0; out_x/y/z/w = 0; accumulator = 0; k = 0; state = IDLE.
- Latency: accept edge E0. The MAC steps run on edges E1..E16. out_valid is high after E16.
- Throughput with out_ready held high: one vertex per 18 cycles (output handshake at E17, IDLE after E17, next accept at E18).
- Backpressure: if out_ready is low, the block stays in DONE indefinitely. out_valid stays high, outputs stay stable, in_ready stays 0.
- in_valid while not in IDLE: ignored, no acceptance.
- Reset at any point, including mid-MAC or in DONE: on the next edge, return to IDLE and clear all registers to their reset values. The partial result is discarded and never presented.
- Saturation is per output element and independent of the other rows.

## Test plan
- Camera view matrix for camera position (0x0234, 0x0416, 0x0396); vertex (0x0234, 0x0416, 0x0396) -> out = (0x0000, 0x0000, 0x0000, 0x0100), with out_valid rising exactly 16 edges after acceptance.
- Same matrix; vertex (0x0100, 0x0200, 0x0300) -> out = (0xFECC, 0xFDEA, 0xFF6A, 0x0100). Then a second vertex back-to-back with out_ready tied high: the second acceptance occurs 18 cycles after the first.
- Saturation: diagonal elements 0x7F00 with (3,3) = 0x0100; vertex (0x7F00, 0x8100, 0x0000) -> out = (0x7FFF, 0x8000, 0x0000, 0x0100).
- Truncation: identity matrix except (0,0) = 0x0080; vertex x = 0x0001 -> out_x = 0x0000. Vertex x = 0xFFFF -> out_x = 0xFFFF.
- Backpressure and input isolation: hold out_ready low for 5 cycles after out_valid rises, and change matrix/in_* and pulse in_valid during MAC and DONE. Required: outputs unchanged, in_ready = 0 throughout, no second acceptance, result matches the originally latched inputs.
- Reset mid-operation: assert Reset at MAC step 8 for one cycle. Required: IDLE next cycle with out_valid = 0 and outputs = 0. A fresh vertex then produces the correct result with no residue from the aborted accumulation.

Source files
------------

// File: rtl/vertex_transform.sv
// Multiplies a vertex (x, y, z, w = 1.0) by a latched 4x4 Q8.8 matrix using one shared MAC,
// one matrix element per cycle, and returns the saturated homogeneous result.
module vertex_transform (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0][15:0] matrix_i,
    input  logic [15:0]       in_x_i,
    input  logic [15:0]       in_y_i,
    input  logic [15:0]       in_z_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [15:0]       out_x_o,
    output logic [15:0]       out_y_o,
    output logic [15:0]       out_z_o,
    output logic [15:0]       out_w_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e             state_q;
    logic [15:0][15:0]  mat_q;
    logic [3:0][15:0]   vec_q;   // index c: 0 = x, 1 = y, 2 = z, 3 = w
    logic signed [35:0] acc_q;
    logic [3:0]         k_q;
    logic [3:0][15:0]   out_q;
    logic               out_valid_q;

    logic [1:0]         row;
    logic [1:0]         col;
    logic signed [15:0] m_el;
    logic signed [15:0] v_el;
    logic signed [31:0] product;
    logic signed [35:0] sum;
    logic signed [35:0] shifted;
    logic [15:0]        sat;

    assign row     = k_q[3:2];
    assign col     = k_q[1:0];
    assign m_el    = mat_q[k_q];
    assign v_el    = vec_q[col];
    assign product = 32'(m_el) * 32'(v_el);
    assign sum     = acc_q + 36'(product);
    assign shifted = sum >>> 8;

    always_comb begin
        sat = shifted[15:0];
        if (shifted > 36'sh000007FFF) begin
            sat = 16'h7FFF;
        end else if (shifted < 36'shFFFFF8000) begin
            sat = 16'h8000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mat_q       <= '0;
            vec_q       <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        mat_q   <= matrix_i;
                        vec_q   <= {16'h0100, in_z_i, in_y_i, in_x_i};
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    // Last column closes the row: commit it and start the next one from zero.
                    if (col == 2'd3) begin
                        out_q[row] <= sat;
                        acc_q      <= '0;
                    end else begin
                        acc_q <= sum;
                    end
                    k_q <= k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign out_valid_o = out_valid_q;
    assign out_x_o     = out_q[0];
    assign out_y_o     = out_q[1];
    assign out_z_o     = out_q[2];
    assign out_w_o     = out_q[3];

endmodule

// File: tb/tb_vertex_transform.sv
// Directed bench for vertex_transform: latency, throughput, saturation, truncation,
// backpressure/input isolation and mid-operation reset.
module tb_vertex_transform;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0][15:0] matrix;
    logic [15:0]       in_x, in_y, in_z;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       out_x, out_y, out_z, out_w;
    logic              out_valid;
    logic              out_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int lat      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vertex_transform u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .matrix_i    (matrix),
        .in_x_i      (in_x),
        .in_y_i      (in_y),
        .in_z_i      (in_z),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_x_o     (out_x),
        .out_y_o     (out_y),
        .out_z_o     (out_z),
        .out_w_o     (out_w),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {out_w, out_z, out_y, out_x};
    endfunction

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(got[i*16 +: 16]), 32'(exp[i*16 +: 16]));
        end
    endtask

    // Presents one vertex and returns just after the accepting edge.
    task automatic send(input logic [15:0][15:0] m, input logic [15:0] x, y, z);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        matrix   = m;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_valid = 1'b1;
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic collect(output logic [63:0] got);
        int n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (!out_valid) check("result_timeout", 32'd0, 32'd1);
        lat       = cyc - acc_cyc;
        got       = outs();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [15:0][15:0] m_view, m_sat, m_trunc, m_junk;
    logic [63:0]       got, got1, held;
    logic [63:0]       exp_eye, exp_v;
    int                acc1, acc2;
    logic              got1_seen, bad_ready, bad_hold;

    initial begin
        m_view = '0;
        m_view[0]  = 16'h0100;
        m_view[5]  = 16'h0100;
        m_view[10] = 16'h0100;
        m_view[15] = 16'h0100;
        m_view[3]  = 16'hFDCC;
        m_view[7]  = 16'hFBEA;
        m_view[11] = 16'hFC6A;
        m_sat = '0;
        m_sat[0]  = 16'h7F00;
        m_sat[5]  = 16'h7F00;
        m_sat[10] = 16'h7F00;
        m_sat[15] = 16'h0100;
        m_trunc = '0;
        m_trunc[0]  = 16'h0080;
        m_trunc[5]  = 16'h0100;
        m_trunc[10] = 16'h0100;
        m_trunc[15] = 16'h0100;
        for (int i = 0; i < 16; i++) m_junk[i] = 16'h1234 + 16'(i * 16'h0111);
        exp_eye = {16'h0100, 16'h0000, 16'h0000, 16'h0000};
        exp_v   = {16'h0100, 16'hFF6A, 16'hFDEA, 16'hFECC};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        matrix = '0; in_x = '0; in_y = '0; in_z = '0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_lo", outs()[31:0], 32'd0);
        check("rst_out_hi", outs()[63:32], 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vertex at the camera position lands on the origin.
        send(m_view, 16'h0234, 16'h0416, 16'h0396);
        collect(got);
        check("latency", 32'(lat), 32'd16);
        check_vec("eye", got, exp_eye);

        send(m_view, 16'h0100, 16'h0200, 16'h0300);
        collect(got);
        check_vec("view", got, exp_v);

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        send(m_view, 16'h0100, 16'h0200, 16'h0300);
        acc1 = acc_cyc;
        in_valid = 1'b1;
        in_x = 16'h0234; in_y = 16'h0416; in_z = 16'h0396;
        got1_seen = 1'b0;
        got1 = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid && !got1_seen) begin
                got1 = outs();
                got1_seen = 1'b1;
            end
            if (in_ready) break;
        end
        step();
        acc2 = cyc;
        in_valid = 1'b0;
        check("b2b_spacing", 32'(acc2 - acc1), 32'd18);
        check_vec("b2b_first", got1, exp_v);
        collect(got);
        check_vec("b2b_second", got, exp_eye);
        out_ready = 1'b0;

        send(m_sat, 16'h7F00, 16'h8100, 16'h0000);
        collect(got);
        check_vec("sat", got, {16'h0100, 16'h0000, 16'h8000, 16'h7FFF});

        send(m_trunc, 16'h0001, 16'h0200, 16'hFF00);
        collect(got);
        check_vec("trunc_pos", got, {16'h0100, 16'hFF00, 16'h0200, 16'h0000});
        send(m_trunc, 16'hFFFF, 16'h0000, 16'h0000);
        collect(got);
        check("trunc_neg", 32'(got[15:0]), 32'h0000FFFF);

        // Backpressure with inputs disturbed during MAC and DONE.
        send(m_view, 16'h0100, 16'h0200, 16'h0300);
        bad_ready = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            matrix = m_junk; in_x = 16'h5555 + 16'(i); in_y = 16'hAAAA; in_z = 16'h7777;
            in_valid = ~in_valid;
            if (in_ready) bad_ready = 1'b1;
            step();
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        held = outs();
        bad_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_x = 16'h0F0F ^ 16'(i);
            step();
            if (in_ready) bad_ready = 1'b1;
            if (!out_valid || outs() !== held) bad_hold = 1'b1;
        end
        check("bp_in_ready_low", 32'(bad_ready), 32'd0);
        check("bp_outputs_stable", 32'(bad_hold), 32'd0);
        check_vec("bp_result", held, exp_v);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("handshake_in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        check("after_hs_out_valid", 32'(out_valid), 32'd0);
        step();
        step();
        check("no_second_accept", 32'(in_ready), 32'd1);

        // Reset while the MAC is at step 8.
        send(m_view, 16'h0100, 16'h0200, 16'h0300);
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_lo", outs()[31:0], 32'd0);
        check("midrst_out_hi", outs()[63:32], 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_idle", 32'(in_ready), 32'd1);
        send(m_view, 16'h0100, 16'h0200, 16'h0300);
        collect(got);
        check_vec("after_rst", got, exp_v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
